// File: rtl/instruction_fetch_axi.sv
// AXI4-Lite instruction fetch master with a one-entry address tag.
// Feeds the single-cycle core one 32-bit word per PC; the core stalls on !valid.
module instruction_fetch_axi #(
    parameter int              XLEN            = 32,
    parameter int              ADDR_WIDTH      = 32,
    parameter logic [XLEN-1:0] NOP_INSTRUCTION = 32'h00000013
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic [ADDR_WIDTH-1:0] i_Instruction_Addr,
    input  logic                  i_Flush,
    output logic [XLEN-1:0]       o_Instruction,
    output logic                  o_Instruction_Valid,
    output logic                  o_Fetch_Error,
    output logic [ADDR_WIDTH-1:0] o_Axi_Araddr,
    output logic [2:0]            o_Axi_Arprot,
    output logic                  o_Axi_Arvalid,
    input  logic                  i_Axi_Arready,
    input  logic [XLEN-1:0]       i_Axi_Rdata,
    input  logic [1:0]            i_Axi_Rresp,
    input  logic                  i_Axi_Rvalid,
    output logic                  o_Axi_Rready
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_ADDR         = 2'd1;
    localparam logic [1:0] S_DATA         = 2'd2;
    localparam logic [1:0] S_RESP_DISCARD = 2'd3;

    logic [1:0]            r_State;
    logic [ADDR_WIDTH-1:0] r_Tag;
    logic                  r_Tag_Valid;
    logic [XLEN-1:0]       r_Data;
    logic                  r_Err;
    logic                  r_Flush_Pend;

    logic w_Hit;
    logic w_Misaligned;
    logic w_Ar_Hs;
    logic w_R_Hs;
    logic w_Start;

    // Tag match against the live PC, plus handshake and fetch-start decode
    always_comb begin
        w_Hit = r_Tag_Valid
             && (r_Tag == i_Instruction_Addr)
             && (r_State != S_RESP_DISCARD);
        w_Misaligned = |i_Instruction_Addr[1:0];
        w_Ar_Hs      = o_Axi_Arvalid && i_Axi_Arready;
        w_R_Hs       = i_Axi_Rvalid && o_Axi_Rready;
        w_Start      = (r_State == S_IDLE) && !w_Hit && !w_Misaligned;
    end

    assign o_Instruction       = r_Data;
    assign o_Instruction_Valid = w_Hit;
    assign o_Fetch_Error       = w_Hit && r_Err;
    assign o_Axi_Arprot        = 3'b100;

    // AXI read channel sequencing: one outstanding request at a time
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State       <= S_IDLE;
            o_Axi_Araddr  <= '0;
            o_Axi_Arvalid <= 1'b0;
            o_Axi_Rready  <= 1'b0;
            r_Flush_Pend  <= 1'b0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (w_Start) begin
                        o_Axi_Araddr  <= i_Instruction_Addr;
                        o_Axi_Arvalid <= 1'b1;
                        r_State       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_Ar_Hs) begin
                        o_Axi_Arvalid <= 1'b0;
                        o_Axi_Rready  <= 1'b1;
                        r_Flush_Pend  <= 1'b0;
                        if (r_Flush_Pend || i_Flush) begin
                            r_State <= S_RESP_DISCARD;
                        end else begin
                            r_State <= S_DATA;
                        end
                    end else if (i_Flush) begin
                        r_Flush_Pend <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_R_Hs) begin
                        o_Axi_Rready <= 1'b0;
                        r_State      <= S_IDLE;
                    end else if (i_Flush) begin
                        r_State <= S_RESP_DISCARD;
                    end
                end
                default: begin
                    if (w_R_Hs) begin
                        o_Axi_Rready <= 1'b0;
                        r_State      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Held word/tag: flush wins, then misaligned fill, then response capture
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Tag       <= '0;
            r_Tag_Valid <= 1'b0;
            r_Data      <= '0;
            r_Err       <= 1'b0;
        end else if (i_Flush) begin
            r_Tag_Valid <= 1'b0;
        end else if (r_State == S_IDLE && !w_Hit) begin
            if (w_Misaligned) begin
                r_Tag       <= i_Instruction_Addr;
                r_Tag_Valid <= 1'b1;
                r_Err       <= 1'b1;
                r_Data      <= NOP_INSTRUCTION;
            end else begin
                r_Tag_Valid <= 1'b0;
            end
        end else if (r_State == S_DATA && w_R_Hs) begin
            if (i_Instruction_Addr == o_Axi_Araddr) begin
                r_Tag       <= o_Axi_Araddr;
                r_Tag_Valid <= 1'b1;
                r_Err       <= (i_Axi_Rresp != 2'b00);
                r_Data      <= (i_Axi_Rresp == 2'b00) ? i_Axi_Rdata
                                                      : NOP_INSTRUCTION;
            end else begin
                r_Tag_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_axi.sv
// Self-checking bench for instruction_fetch_axi: directed plan steps,
// then randomized PCs/flushes/slave delays checked against a word model.
module tb_instruction_fetch_axi;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        valid;
    logic        ferr;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_cmp  = 0;
    int n_fail = 0;

    int          ar_delay = 0;
    int          r_delay  = 0;
    int          n_ar     = 0;
    int          mem_gen  = 0;
    logic [31:0] err_pc   = 32'hFFFF_FFF0;

    instruction_fetch_axi dut (
        .i_Clock             (clk),
        .i_Reset_n           (rst_n),
        .i_Instruction_Addr  (pc),
        .i_Flush             (flush),
        .o_Instruction       (instr),
        .o_Instruction_Valid (valid),
        .o_Fetch_Error       (ferr),
        .o_Axi_Araddr        (araddr),
        .o_Axi_Arprot        (arprot),
        .o_Axi_Arvalid       (arvalid),
        .i_Axi_Arready       (arready),
        .i_Axi_Rdata         (rdata),
        .i_Axi_Rresp         (rresp),
        .i_Axi_Rvalid        (rvalid),
        .o_Axi_Rready        (rready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a,
                                             input int g);
        logic [31:0] gv;
        gv = g;
        if (a == 32'h0) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ {gv[15:0], 16'h0} ^ 32'h1234_0057;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return a[12] || (a == err_pc);
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs,
                          input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (valid) break;
        end
        check1(tag, valid, 1'b1);
    endtask

    // Reference: what a valid output must show for the current PC
    task automatic check_out();
        logic [31:0] ew;
        logic        ee;
        if (|pc[1:0]) begin
            ew = NOP; ee = 1'b1;
        end else if (is_err(pc)) begin
            ew = NOP; ee = 1'b1;
        end else begin
            ew = mem_word(pc, mem_gen); ee = 1'b0;
        end
        if (valid) begin
            check32("rnd_instr", instr, ew);
            check1("rnd_err", ferr, ee);
        end else begin
            check1("rnd_err_novalid", ferr, 1'b0);
        end
    endtask

    // AXI slave model plus protocol monitor, evaluated on the falling edge
    logic        prev_arv, prev_arr;
    logic [31:0] prev_ara;
    initial begin
        int          ar_cnt, r_cnt;
        bit          have_req, ar_pend, r_pend;
        logic [31:0] req_data;
        logic [1:0]  req_resp;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        ar_cnt = 0; r_cnt = 0; have_req = 0; ar_pend = 0; r_pend = 0;
        req_data = 0; req_resp = 0;
        prev_arv = 0; prev_arr = 0; prev_ara = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; rvalid = 0; ar_cnt = 0; r_cnt = 0;
                have_req = 0; ar_pend = 0; r_pend = 0;
                prev_arv = 0; prev_arr = 0;
            end else begin
                check32("arprot", {29'b0, arprot}, 32'h4);
                check1("ar_while_rready", arvalid && rready, 1'b0);
                if (prev_arv && !prev_arr) begin
                    check1("arvalid_hold", arvalid, 1'b1);
                    check32("araddr_stable", araddr, prev_ara);
                end
                if (r_pend) begin
                    r_pend = 0; rvalid = 0; have_req = 0;
                end
                if (ar_pend) begin
                    ar_pend = 0; have_req = 1; r_cnt = 0;
                end
                if (!have_req && arvalid) begin
                    arready = (ar_cnt >= ar_delay);
                    ar_cnt++;
                end else begin
                    arready = 0; ar_cnt = 0;
                end
                if (have_req && !rvalid) begin
                    if (r_cnt >= r_delay) begin
                        rvalid = 1; rdata = req_data; rresp = req_resp;
                    end else begin
                        r_cnt++;
                    end
                end
                if (arvalid && arready) begin
                    ar_pend = 1;
                    n_ar++;
                    if (is_err(araddr)) begin
                        req_data = 32'hDEADBEEF; req_resp = 2'b10;
                    end else begin
                        req_data = mem_word(araddr, mem_gen);
                        req_resp = 2'b00;
                    end
                end
                if (rvalid && rready) r_pend = 1;
                prev_arv = arvalid; prev_ara = araddr; prev_arr = arready;
            end
        end
    end

    initial begin
        int n0;
        rst_n = 0; pc = 32'h0; flush = 0;

        // Reset state
        repeat (3) step();
        check1("rst_arvalid", arvalid, 1'b0);
        check1("rst_rready", rready, 1'b0);
        check1("rst_valid", valid, 1'b0);
        check1("rst_err", ferr, 1'b0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_araddr", araddr, 32'h0);

        // Zero-wait fetch of PC 0: AR at cycle 1, valid at cycle 3
        rst_n = 1;
        step();
        check1("c1_arvalid", arvalid, 1'b1);
        check32("c1_araddr", araddr, 32'h0);
        step();
        check1("c2_arvalid", arvalid, 1'b0);
        check1("c2_valid", valid, 1'b0);
        step();
        check1("c3_valid", valid, 1'b1);
        check32("c3_instr", instr, 32'h00500093);
        check1("c3_err", ferr, 1'b0);

        // Held PC: no refetch
        n0 = n_ar;
        for (int i = 0; i < 10; i++) begin
            step();
            check1("hold_arvalid", arvalid, 1'b0);
            check1("hold_valid", valid, 1'b1);
        end
        check32("hold_no_refetch", n_ar, n0);

        // PC moves during a stalled AR: address held, old data dropped
        ar_delay = 5;
        pc = 32'h4;
        step();
        check1("pc4_arvalid", arvalid, 1'b1);
        check32("pc4_araddr", araddr, 32'h4);
        pc = 32'h8;
        for (int i = 0; i < 5; i++) begin
            step();
            check32("stall_araddr", araddr, 32'h4);
            check1("stall_valid", valid, 1'b0);
        end
        ar_delay = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check1("pc8_novalid", valid, 1'b0);
            if (arvalid && araddr == 32'h8) break;
        end
        check32("pc8_araddr", araddr, 32'h8);
        wait_valid("pc8_valid", 20);
        check32("pc8_instr", instr, mem_word(32'h8, mem_gen));
        check1("pc8_err", ferr, 1'b0);

        // Error response
        err_pc = 32'h10;
        pc = 32'h10;
        wait_valid("slverr_valid", 20);
        check1("slverr_err", ferr, 1'b1);
        check32("slverr_instr", instr, NOP);
        err_pc = 32'hFFFF_FFF0;

        // Misaligned PC: no bus traffic, NOP with error on cycle 1
        n0 = n_ar;
        pc = 32'h6;
        step();
        check1("mis_valid", valid, 1'b1);
        check1("mis_err", ferr, 1'b1);
        check32("mis_instr", instr, NOP);
        check1("mis_arvalid", arvalid, 1'b0);
        repeat (5) step();
        check32("mis_no_ar", n_ar, n0);

        // Flush coincident with R handshake
        pc = 32'h20;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rready) break;
        end
        check1("fl_rready", rready, 1'b1);
        @(negedge clk);
        #1;
        check1("fl_rvalid", rvalid, 1'b1);
        flush = 1;
        step();
        flush = 0;
        check1("fl_valid", valid, 1'b0);
        step();
        check1("fl_refetch", arvalid, 1'b1);
        check32("fl_refetch_addr", araddr, 32'h20);
        wait_valid("fl_valid2", 20);
        check32("fl_instr", instr, mem_word(32'h20, mem_gen));

        // Asynchronous reset mid-transaction
        pc = 32'h40;
        step();
        check1("ar40_arvalid", arvalid, 1'b1);
        #1 rst_n = 0;
        #1;
        check1("arst_arvalid", arvalid, 1'b0);
        check1("arst_valid", valid, 1'b0);
        check32("arst_instr", instr, 32'h0);
        check32("arst_araddr", araddr, 32'h0);
        step();
        rst_n = 1;
        wait_valid("post_rst_valid", 20);
        check32("post_rst_instr", instr, mem_word(32'h40, mem_gen));

        // Randomized PCs, slave delays and flushes (with memory rewrite)
        for (int it = 0; it < 300; it++) begin
            int sel, mode, hold;
            sel = $urandom_range(0, 9);
            if (sel < 6) pc = 32'h100 + 4 * $urandom_range(0, 7);
            else if (sel < 8) pc = 32'h1000 + 4 * $urandom_range(0, 3);
            else pc = 32'h200 + 4 * $urandom_range(0, 3)
                      + $urandom_range(1, 3);
            ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            hold = (mode == 0) ? 40 : $urandom_range(1, 6);
            for (int c = 0; c < hold; c++) begin
                bit fl;
                fl = (mode != 0) && ($urandom_range(0, 7) == 0);
                if (fl) begin
                    flush = 1;
                    mem_gen++;
                end
                step();
                if (fl) begin
                    flush = 0;
                    check1("rnd_flush_clears", valid, 1'b0);
                end
                check_out();
                if (mode == 0 && valid) break;
            end
            if (mode == 0) check1("rnd_settle", valid, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_axi.md
Name: instruction_fetch_axi

Overview:
- AXI4-Lite read master that fetches one 32-bit instruction word for the core's current PC.
- Sits directly upstream of the single-cycle core. It presents o_Instruction and o_Instruction_Valid; the core stalls while valid is low.
- Holds a one-entry tag so a PC held across stall cycles is never re-fetched.
- Discards in-flight responses when the PC changes, and supports an explicit flush.

Parameters:
XLEN, 32, instruction/data word width (fixed 32; RDATA width)
ADDR_WIDTH, 32, AXI address and PC width
NOP_INSTRUCTION, 32'h00000013, word driven on o_Instruction after an AXI error response

Ports:
i_Clock  input  1  core clock, all logic on rising edge
i_Reset_n  input  1  asynchronous active-low reset
i_Instruction_Addr  input  ADDR_WIDTH  current PC from core
i_Flush  input  1  invalidate held tag (e.g. after self-modifying store); one-cycle pulse
o_Instruction  output  XLEN  fetched instruction word
o_Instruction_Valid  output  1  o_Instruction belongs to current i_Instruction_Addr
o_Fetch_Error  output  1  current word came from SLVERR/DECERR or misaligned PC
o_Axi_Araddr  output  ADDR_WIDTH  read address
o_Axi_Arprot  output  3  constant 3'b100 (instruction, secure, unprivileged)
o_Axi_Arvalid  output  1  address valid
i_Axi_Arready  input  1  address accepted
i_Axi_Rdata  input  XLEN  read data
i_Axi_Rresp  input  2  read response
i_Axi_Rvalid  input  1  data valid
o_Axi_Rready  output  1  data accept

Behaviour:
- Reset is asynchronous and active-low: i_Reset_n low immediately forces the following, independent of the clock: state IDLE, tag invalid, o_Instruction=0, o_Fetch_Error=0, o_Axi_Arvalid=0, o_Axi_Rready=0, o_Axi_Araddr=0. Release is synchronous to i_Clock.
- Held registers: r_Tag (address), r_Tag_Valid, r_Data, r_Err.
- Combinational hit: hit = r_Tag_Valid && r_Tag == i_Instruction_Addr && state != RESP_DISCARD.
  - o_Instruction_Valid = hit.
  - o_Instruction = r_Data.
  - o_Fetch_Error = hit && r_Err.
- States:
  - IDLE: if !hit and addr[1:0]==0, latch address into o_Axi_Araddr, assert Arvalid, go to ADDR. If !hit and addr[1:0]!=0, set r_Tag=addr, r_Tag_Valid=1, r_Err=1, r_Data=NOP_INSTRUCTION; no AXI transaction is issued.
  - ADDR: hold Arvalid and Araddr stable until Arready; the address must not change while Arvalid is high, even if the PC changes. On handshake, drop Arvalid, raise Rready, go to DATA.
  - DATA: on Rvalid&&Rready, drop Rready. Then:
    - If i_Instruction_Addr still equals Araddr: r_Data = (Rresp==2'b00) ? Rdata : NOP_INSTRUCTION; r_Err = (Rresp!=0); r_Tag = Araddr; r_Tag_Valid = 1.
    - Otherwise the response is discarded and the tag is left invalid.
    - Go to IDLE in both cases.
- Latency: with zero-wait slave (Arready=1, Rvalid one cycle after AR handshake), PC presented at cycle 0 gives Arvalid at cycle 1, Rvalid at cycle 2, and o_Instruction_Valid high at cycle 3.
- Exactly one outstanding transaction; Arvalid is never asserted while in DATA.
- PC change while idle with valid tag: hit drops combinationally the same cycle and a new fetch starts next edge.
- i_Flush clears r_Tag_Valid on the next edge.
  - If a transaction is in flight, it completes and its data is discarded, even if the PC is unchanged.
  - Flush in the same cycle as the R handshake takes priority: the tag ends invalid.
- Reset asserted mid-transaction abandons the AXI transaction (interconnect is reset together).
- o_Instruction changes only on a tag update; it is stable while valid is high.

Test Plan:
- Reset then PC=0x00000000, slave zero-wait returns 0x00500093 OKAY -> Arvalid at cycle 1 with Araddr=0; Valid=1, Instruction=0x00500093, Error=0 at cycle 3.
- Hold PC=0x0 for 10 cycles after valid -> no further Arvalid, Valid stays 1.
- PC=0x4, slave holds Arready low 5 cycles and core changes PC to 0x8 during wait -> Araddr stays 0x4 until handshake. 0x4 data is discarded and Valid stays 0. Second AR to 0x8 follows; Valid=1 for 0x8 data.
- PC=0x10, slave returns Rresp=2'b10, Rdata=0xDEADBEEF -> Valid=1, Error=1, Instruction=0x00000013.
- PC=0x6 (misaligned) -> no Arvalid ever; Valid=1, Error=1, Instruction=0x00000013 on cycle 1.
- Flush pulse coincident with R handshake for PC=0x20 -> tag invalid and Valid=0; a refetch of 0x20 is issued the following cycle.
